// File: rtl/power_sequencer.sv
// Power-management gate: debounces shutdown requests, stages IO groups on, forces safe levels on trip.
// Optional watchdog trip source is compiled in with `define PM_WATCHDOG_EN.
module power_sequencer #(
  parameter int                   NUM_IN          = 2,
  parameter int                   NUM_IOS         = 89,
  parameter int                   NUM_GROUPS      = 4,
  parameter int                   DEBOUNCE_CYCLES = 50000,
  parameter int                   STAGGER_CYCLES  = 500000,
  parameter logic [NUM_IOS-1:0]   SAFE_LEVEL      = {NUM_IOS{1'b0}},
  parameter int                   WDT_CYCLES      = 5000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_IN-1:0]     shutdown,
  input  logic                  rearm,
  input  logic                  wdt_kick,
  input  logic [NUM_IOS-1:0]    gpio_in,
  output logic [NUM_IOS-1:0]    gpio_out,
  output logic [NUM_GROUPS-1:0] group_en,
  output logic [1:0]            state,
  output logic [NUM_IN:0]       cause
);

  localparam int GROUP_W = (NUM_IOS + NUM_GROUPS - 1) / NUM_GROUPS;
  localparam int DW      = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int SW      = $clog2(STAGGER_CYCLES) + 1;

  localparam logic [1:0] ST_OFF      = 2'b00;
  localparam logic [1:0] ST_STAGING  = 2'b01;
  localparam logic [1:0] ST_ON       = 2'b10;
  localparam logic [1:0] ST_SHUTDOWN = 2'b11;

  logic [NUM_IN-1:0]     sync1;
  logic [NUM_IN-1:0]     sync2;
  logic [NUM_IN-1:0]     deb;
  logic [DW-1:0]         deb_cnt [NUM_IN];
  logic [SW-1:0]         stagger_cnt;
  logic                  stagger_done;
  logic [NUM_GROUPS-1:0] next_en;
  logic [NUM_IOS-1:0]    io_en;
  logic                  req;
  logic                  wdt_trip;
  logic                  trip;
  logic [NUM_IN:0]       trip_cause;

  // Debounced inputs reset asserted so the IO stays safe until inputs prove clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '1;
      for (int k = 0; k < NUM_IN; k++) deb_cnt[k] <= '0;
    end else begin
      sync1 <= shutdown;
      sync2 <= sync1;
      for (int k = 0; k < NUM_IN; k++) begin
        if (sync2[k] == deb[k]) begin
          deb_cnt[k] <= '0;
        end else if (deb_cnt[k] == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb[k]     <= ~deb[k];
          deb_cnt[k] <= '0;
        end else begin
          deb_cnt[k] <= deb_cnt[k] + 1'b1;
        end
      end
    end
  end

  assign req = |deb;

`ifdef PM_WATCHDOG_EN
  localparam int WW = $clog2(WDT_CYCLES) + 1;

  logic [WW-1:0] wdt_cnt;
  logic          wdt_active;

  assign wdt_active = (state == ST_STAGING) || (state == ST_ON);
  // A kick landing on the timeout cycle suppresses the trip.
  assign wdt_trip   = wdt_active && !wdt_kick && (wdt_cnt == WW'(WDT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || !wdt_active || wdt_kick || wdt_trip) begin
      wdt_cnt <= '0;
    end else begin
      wdt_cnt <= wdt_cnt + 1'b1;
    end
  end
`else
  logic unused_wdt;

  assign wdt_trip   = 1'b0;
  assign unused_wdt = wdt_kick ^ (WDT_CYCLES > 0);
`endif

  assign trip         = req | wdt_trip;
  assign trip_cause   = {wdt_trip, deb};
  assign stagger_done = (stagger_cnt == SW'(STAGGER_CYCLES - 1));
  assign next_en      = (group_en << 1) | NUM_GROUPS'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_OFF;
      group_en    <= '0;
      cause       <= '0;
      stagger_cnt <= '0;
    end else begin
      case (state)
        ST_OFF: begin
          stagger_cnt <= '0;
          if (!req) begin
            state    <= ST_STAGING;
            group_en <= NUM_GROUPS'(1);
          end
        end
        ST_STAGING: begin
          // A trip on the same cycle as a timer expiry wins; no further group is enabled.
          if (trip) begin
            state       <= ST_SHUTDOWN;
            group_en    <= '0;
            cause       <= cause | trip_cause;
            stagger_cnt <= '0;
          end else if (stagger_done) begin
            stagger_cnt <= '0;
            group_en    <= next_en;
            if (next_en[NUM_GROUPS-1]) state <= ST_ON;
          end else begin
            stagger_cnt <= stagger_cnt + 1'b1;
          end
        end
        ST_ON: begin
          stagger_cnt <= '0;
          if (trip) begin
            state    <= ST_SHUTDOWN;
            group_en <= '0;
            cause    <= cause | trip_cause;
          end
        end
        default: begin
          stagger_cnt <= '0;
          group_en    <= '0;
          if (rearm && !trip) begin
            state <= ST_OFF;
            cause <= '0;
          end else begin
            cause <= cause | trip_cause;
          end
        end
      endcase
    end
  end

  always_comb begin
    io_en = '0;
    for (int i = 0; i < NUM_IOS; i++) io_en[i] = group_en[i / GROUP_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_out <= SAFE_LEVEL;
    end else begin
      gpio_out <= (gpio_in & io_en) | (SAFE_LEVEL & ~io_en);
    end
  end

endmodule

// File: tb/tb_power_sequencer.sv
// Directed bench for power_sequencer: power-up staging, glitch rejection, trips, re-arm and reset.
module tb_power_sequencer;

  logic       clk;
  logic       reset;
  logic [1:0] shutdown;
  logic       rearm;
  logic       wdt_kick;
  logic [9:0] gpio_in;
  logic [9:0] gpio_out;
  logic [2:0] group_en;
  logic [1:0] state;
  logic [2:0] cause;

  int tests_run    = 0;
  int tests_failed = 0;
  logic kick_en    = 1'b1;
  int kick_div     = 0;

  power_sequencer #(
    .NUM_IN(2), .NUM_IOS(10), .NUM_GROUPS(3), .DEBOUNCE_CYCLES(4),
    .STAGGER_CYCLES(8), .SAFE_LEVEL(10'h2A5), .WDT_CYCLES(20)
  ) dut (
    .clk(clk), .reset(reset), .shutdown(shutdown), .rearm(rearm), .wdt_kick(wdt_kick),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .group_en(group_en), .state(state), .cause(cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Background kicker every 10 cycles keeps the optional watchdog quiet until a test stops it.
  initial begin
    wdt_kick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      wdt_kick = kick_en && (kick_div == 0);
      kick_div = (kick_div == 9) ? 0 : kick_div + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    tick(3);
    tests_run++; if (state !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_state got=%b exp=00", state); end
    tests_run++; if (group_en !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_group_en got=%b exp=000", group_en); end
    tests_run++; if (gpio_out !== 10'h2A5) begin tests_failed++; $display("[TB] FAIL reset_gpio got=%h exp=2a5", gpio_out); end
    tests_run++; if (cause !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_cause got=%b exp=000", cause); end
    reset = 1'b0;
  endtask

  task automatic test_power_up;
    tick(4);
    tests_run++; if (state !== 2'b00) begin tests_failed++; $display("[TB] FAIL pu_still_off got=%b exp=00", state); end
    tests_run++; if (gpio_out !== 10'h2A5) begin tests_failed++; $display("[TB] FAIL pu_gpio_safe got=%h exp=2a5", gpio_out); end
    tick(1);
    tests_run++; if (state !== 2'b01) begin tests_failed++; $display("[TB] FAIL pu_staging got=%b exp=01", state); end
    tests_run++; if (group_en !== 3'b001) begin tests_failed++; $display("[TB] FAIL pu_group0 got=%b exp=001", group_en); end
    tick(1);
    tests_run++; if (gpio_out !== 10'h2AF) begin tests_failed++; $display("[TB] FAIL pu_gpio_g0 got=%h exp=2af", gpio_out); end
    tick(6);
    tests_run++; if (group_en !== 3'b001) begin tests_failed++; $display("[TB] FAIL pu_g1_early got=%b exp=001", group_en); end
    tick(1);
    tests_run++; if (group_en !== 3'b011) begin tests_failed++; $display("[TB] FAIL pu_group1 got=%b exp=011", group_en); end
    tick(1);
    tests_run++; if (gpio_out !== 10'h2FF) begin tests_failed++; $display("[TB] FAIL pu_gpio_g1 got=%h exp=2ff", gpio_out); end
    tick(6);
    tests_run++; if (state !== 2'b01) begin tests_failed++; $display("[TB] FAIL pu_on_early got=%b exp=01", state); end
    tick(1);
    tests_run++; if (group_en !== 3'b111) begin tests_failed++; $display("[TB] FAIL pu_group2 got=%b exp=111", group_en); end
    tests_run++; if (state !== 2'b10) begin tests_failed++; $display("[TB] FAIL pu_on got=%b exp=10", state); end
    tick(1);
    tests_run++; if (gpio_out !== 10'h3FF) begin tests_failed++; $display("[TB] FAIL pu_gpio_on got=%h exp=3ff", gpio_out); end
  endtask

  task automatic test_glitch;
    shutdown[0] = 1'b1;
    tick(3);
    shutdown[0] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick(1);
      tests_run++; if (state !== 2'b10) begin tests_failed++; $display("[TB] FAIL glitch_state cyc=%0d got=%b exp=10", c, state); end
      tests_run++; if (gpio_out !== 10'h3FF) begin tests_failed++; $display("[TB] FAIL glitch_gpio cyc=%0d got=%h exp=3ff", c, gpio_out); end
    end
  endtask

  task automatic test_trip;
    shutdown[1] = 1'b1;
    tick(6);
    tests_run++; if (state !== 2'b10) begin tests_failed++; $display("[TB] FAIL trip_early got=%b exp=10", state); end
    tick(1);
    tests_run++; if (state !== 2'b11) begin tests_failed++; $display("[TB] FAIL trip_state got=%b exp=11", state); end
    tests_run++; if (group_en !== 3'b000) begin tests_failed++; $display("[TB] FAIL trip_group_en got=%b exp=000", group_en); end
    tests_run++; if (cause !== 3'b010) begin tests_failed++; $display("[TB] FAIL trip_cause got=%b exp=010", cause); end
    tests_run++; if (gpio_out !== 10'h3FF) begin tests_failed++; $display("[TB] FAIL trip_gpio_early got=%h exp=3ff", gpio_out); end
    tick(1);
    tests_run++; if (gpio_out !== 10'h2A5) begin tests_failed++; $display("[TB] FAIL trip_gpio_safe got=%h exp=2a5", gpio_out); end
  endtask

  task automatic test_rearm;
    rearm = 1'b1;
    tick(1);
    rearm = 1'b0;
    tests_run++; if (state !== 2'b11) begin tests_failed++; $display("[TB] FAIL rearm_ignored got=%b exp=11", state); end
    tests_run++; if (cause !== 3'b010) begin tests_failed++; $display("[TB] FAIL rearm_cause_kept got=%b exp=010", cause); end
    shutdown[1] = 1'b0;
    tick(6);
    tests_run++; if (state !== 2'b11) begin tests_failed++; $display("[TB] FAIL rearm_wait got=%b exp=11", state); end
    rearm = 1'b1;
    tick(1);
    rearm = 1'b0;
    tests_run++; if (state !== 2'b00) begin tests_failed++; $display("[TB] FAIL rearm_off got=%b exp=00", state); end
    tests_run++; if (cause !== 3'b000) begin tests_failed++; $display("[TB] FAIL rearm_cause_clr got=%b exp=000", cause); end
    tick(1);
    tests_run++; if (state !== 2'b01) begin tests_failed++; $display("[TB] FAIL rearm_staging got=%b exp=01", state); end
    tests_run++; if (group_en !== 3'b001) begin tests_failed++; $display("[TB] FAIL rearm_group0 got=%b exp=001", group_en); end
  endtask

  // The request lands on the same edge the stagger timer would enable group 1.
  task automatic test_staging_trip;
    tick(1);
    shutdown[0] = 1'b1;
    tick(6);
    tests_run++; if (group_en !== 3'b001) begin tests_failed++; $display("[TB] FAIL stg_pre got=%b exp=001", group_en); end
    tick(1);
    tests_run++; if (state !== 2'b11) begin tests_failed++; $display("[TB] FAIL stg_state got=%b exp=11", state); end
    tests_run++; if (group_en !== 3'b000) begin tests_failed++; $display("[TB] FAIL stg_group_en got=%b exp=000", group_en); end
    tests_run++; if (cause !== 3'b001) begin tests_failed++; $display("[TB] FAIL stg_cause got=%b exp=001", cause); end
    tick(1);
    tests_run++; if (gpio_out !== 10'h2A5) begin tests_failed++; $display("[TB] FAIL stg_gpio got=%h exp=2a5", gpio_out); end
    shutdown[1] = 1'b1;
    tick(7);
    tests_run++; if (cause !== 3'b011) begin tests_failed++; $display("[TB] FAIL stg_cause_accum got=%b exp=011", cause); end
    shutdown = 2'b00;
    tick(6);
    tests_run++; if (state !== 2'b11) begin tests_failed++; $display("[TB] FAIL stg_held got=%b exp=11", state); end
  endtask

  task automatic test_reset_in_shutdown;
    reset = 1'b1;
    tick(1);
    tests_run++; if (state !== 2'b00) begin tests_failed++; $display("[TB] FAIL rst_sd_state got=%b exp=00", state); end
    tests_run++; if (cause !== 3'b000) begin tests_failed++; $display("[TB] FAIL rst_sd_cause got=%b exp=000", cause); end
    tests_run++; if (gpio_out !== 10'h2A5) begin tests_failed++; $display("[TB] FAIL rst_sd_gpio got=%h exp=2a5", gpio_out); end
    tick(1);
    reset = 1'b0;
    tick(3);
    tests_run++; if (state !== 2'b00) begin tests_failed++; $display("[TB] FAIL rst_sd_off got=%b exp=00", state); end
    tick(2);
    tests_run++; if (state !== 2'b01) begin tests_failed++; $display("[TB] FAIL rst_sd_restage got=%b exp=01", state); end
  endtask

`ifdef PM_WATCHDOG_EN
  task automatic test_watchdog;
    int waited;
    logic left_on;
    waited = 0;
    while (state !== 2'b10 && waited < 60) begin
      tick(1);
      waited++;
    end
    tests_run++; if (state !== 2'b10) begin tests_failed++; $display("[TB] FAIL wdt_reach_on got=%b exp=10", state); end
    left_on = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick(1);
      if (state !== 2'b10) left_on = 1'b1;
    end
    tests_run++; if (left_on !== 1'b0) begin tests_failed++; $display("[TB] FAIL wdt_kicked_trip got=%b exp=0", left_on); end
    kick_en = 1'b0;
    waited = 0;
    while (state !== 2'b11 && waited < 40) begin
      tick(1);
      waited++;
    end
    tests_run++; if (state !== 2'b11) begin tests_failed++; $display("[TB] FAIL wdt_trip_state got=%b exp=11", state); end
    tests_run++; if (cause !== 3'b100) begin tests_failed++; $display("[TB] FAIL wdt_trip_cause got=%b exp=100", cause); end
    tests_run++; if (group_en !== 3'b000) begin tests_failed++; $display("[TB] FAIL wdt_group_en got=%b exp=000", group_en); end
  endtask
`endif

  initial begin
    reset    = 1'b1;
    shutdown = 2'b00;
    rearm    = 1'b0;
    gpio_in  = 10'h3FF;
    test_reset();
    test_power_up();
    test_glitch();
    test_trip();
    test_rearm();
    test_staging_trip();
    test_reset_in_shutdown();
`ifdef PM_WATCHDOG_EN
    test_watchdog();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
